// File: rtl/serdes_lb_checker.sv
// serdes_lb_checker
// RX-side checker for the comma-mode loopback test pattern. Each receive word
// must carry exactly one K_CHAR lane, with FILL_CHAR in the other seven lanes.
// The checker hunts for a stable comma lane, locks onto it, and then counts
// checked words and pattern errors.
//
// Ports:
//   rx_clk                receive word clock
//   rx_rstn_i             asynchronous active-low reset
//   rx_data_i[63:0]       decoded RX word, lane n = bits [8n+7:8n]
//   rx_char_is_k_i[7:0]   per-lane K flag
//   rx_not_in_table_i[7:0] per-lane 8b/10b code violation
//   rx_disp_err_i[7:0]    per-lane disparity error
//   rx_byte_is_aligned_i  comma alignment valid; when low the word is ignored
//   cnt_clear_i           synchronous clear of both counters
//   locked_o              high while in CHECK
//   k_pos_o[2:0]          locked comma lane
//   err_o                 one-cycle pulse for each bad word seen in CHECK
//   err_cnt_o[31:0]       saturating error count
//   word_cnt_o[47:0]      wrapping count of words checked in CHECK
module serdes_lb_checker #(
  parameter logic [7:0]  K_CHAR    = 8'hBC,
  parameter logic [7:0]  FILL_CHAR = 8'h4A,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned LOSS_CNT  = 4
) (
  input  logic        rx_clk,
  input  logic        rx_rstn_i,
  input  logic [63:0] rx_data_i,
  input  logic [7:0]  rx_char_is_k_i,
  input  logic [7:0]  rx_not_in_table_i,
  input  logic [7:0]  rx_disp_err_i,
  input  logic        rx_byte_is_aligned_i,
  input  logic        cnt_clear_i,
  output logic        locked_o,
  output logic [2:0]  k_pos_o,
  output logic        err_o,
  output logic [31:0] err_cnt_o,
  output logic [47:0] word_cnt_o
);

  typedef enum logic {ST_HUNT = 1'b0, ST_CHECK = 1'b1} state_e;

  localparam logic [7:0] LOCK_RUN = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_RUN = 8'(LOSS_CNT);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cand_q, cand_d;
  logic [7:0]  good_run_q, good_run_d;
  logic [7:0]  bad_run_q, bad_run_d;
  logic [2:0]  k_pos_q, k_pos_d;
  logic        err_q, err_d;
  logic [31:0] err_cnt_q, err_cnt_d, err_cnt_nx_s;
  logic [47:0] word_cnt_q, word_cnt_d, word_cnt_nx_s;
  logic [7:0]  run_s;

  logic        bytes_ok_s;
  logic        good_s;
  logic [2:0]  lane_s;

  // Word classification: each lane must hold K_CHAR where its K flag is set
  // and FILL_CHAR elsewhere; with exactly one K flag this is the full pattern.
  always_comb begin
    bytes_ok_s = 1'b1;
    lane_s     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      bytes_ok_s = bytes_ok_s &
                   (rx_data_i[8*i +: 8] == (rx_char_is_k_i[i] ? K_CHAR : FILL_CHAR));
      if (rx_char_is_k_i[i]) begin
        lane_s = 3'(i);
      end else begin
        lane_s = lane_s;
      end
    end
    good_s = bytes_ok_s && (popcount8(rx_char_is_k_i) == 4'd1) &&
             (rx_not_in_table_i == 8'd0) && (rx_disp_err_i == 8'd0);
  end

  // Hunt/check state machine and counter next-state.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    good_run_d    = good_run_q;
    bad_run_d     = bad_run_q;
    k_pos_d       = k_pos_q;
    err_d         = 1'b0;
    err_cnt_nx_s  = err_cnt_q;
    word_cnt_nx_s = word_cnt_q;
    run_s         = 8'd0;

    if (!rx_byte_is_aligned_i) begin
      // Alignment loss drops lock; HUNT simply ignores the word.
      if (state_q == ST_CHECK) begin
        state_d    = ST_HUNT;
        good_run_d = 8'd0;
        bad_run_d  = 8'd0;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (good_s) begin
            if (lane_s == cand_q) begin
              run_s = sat_inc8(good_run_q);
            end else begin
              cand_d = lane_s;
              run_s  = 8'd1;
            end
          end else begin
            run_s = 8'd0;
          end
          good_run_d = run_s;
          if (good_s && (run_s == LOCK_RUN)) begin
            state_d   = ST_CHECK;
            k_pos_d   = lane_s;
            bad_run_d = 8'd0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_CHECK: begin
          word_cnt_nx_s = word_cnt_q + 48'd1;
          if (good_s && (lane_s == k_pos_q)) begin
            bad_run_d = 8'd0;
          end else begin
            err_d        = 1'b1;
            err_cnt_nx_s = (err_cnt_q == 32'hFFFF_FFFF) ? err_cnt_q : err_cnt_q + 32'd1;
            run_s        = sat_inc8(bad_run_q);
            if (run_s == LOSS_RUN) begin
              state_d    = ST_HUNT;
              good_run_d = 8'd0;
              bad_run_d  = 8'd0;
            end else begin
              bad_run_d = run_s;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    // Clear wins over any same-cycle increment; err_o is unaffected.
    err_cnt_d  = cnt_clear_i ? 32'd0 : err_cnt_nx_s;
    word_cnt_d = cnt_clear_i ? 48'd0 : word_cnt_nx_s;
  end

  // State and output registers.
  always_ff @(posedge rx_clk or negedge rx_rstn_i) begin
    if (!rx_rstn_i) begin
      state_q    <= ST_HUNT;
      cand_q     <= 3'd0;
      good_run_q <= 8'd0;
      bad_run_q  <= 8'd0;
      k_pos_q    <= 3'd0;
      err_q      <= 1'b0;
      err_cnt_q  <= 32'd0;
      word_cnt_q <= 48'd0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      k_pos_q    <= k_pos_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign locked_o   = (state_q == ST_CHECK);
  assign k_pos_o    = k_pos_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_serdes_lb_checker.sv
module tb_serdes_lb_checker;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] data;
  logic [7:0]  kf;
  logic [7:0]  nit;
  logic [7:0]  derr;
  logic        aligned;
  logic        clr;
  logic        locked;
  logic [2:0]  k_pos;
  logic        err;
  logic [31:0] err_cnt;
  logic [47:0] word_cnt;

  int checks = 0;
  int errors = 0;

  serdes_lb_checker dut (
    .rx_clk               (clk),
    .rx_rstn_i            (rstn),
    .rx_data_i            (data),
    .rx_char_is_k_i       (kf),
    .rx_not_in_table_i    (nit),
    .rx_disp_err_i        (derr),
    .rx_byte_is_aligned_i (aligned),
    .cnt_clear_i          (clr),
    .locked_o             (locked),
    .k_pos_o              (k_pos),
    .err_o                (err),
    .err_cnt_o            (err_cnt),
    .word_cnt_o           (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply a good pattern word with the comma in the given lane.
  task automatic put_good(input int lane);
    data = 64'h4A4A4A4A_4A4A4A4A;
    data[8*lane +: 8] = 8'hBC;
    kf   = 8'd1 << lane;
    nit  = 8'd0;
    derr = 8'd0;
    aligned = 1'b1;
  endtask

  // One active edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; aligned = 1'b1;
    data = 64'd0; kf = 8'd0; nit = 8'd0; derr = 8'd0;
    #12;
    check("rst_locked", locked, 1'b0);
    check("rst_kpos", k_pos, 3'd0);
    check("rst_err", err, 1'b0);
    check("rst_errcnt", err_cnt, 32'd0);
    check("rst_wordcnt", word_cnt, 48'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // 1: lock on lane 0 after the 4th word
    put_good(0);
    step(); step(); step();
    check("t1_nolock3", locked, 1'b0);
    step();
    check("t1_lock", locked, 1'b1);
    check("t1_kpos", k_pos, 3'd0);
    check("t1_wc_lockword", word_cnt, 48'd0);
    step();
    check("t1_wc", word_cnt, 48'd1);
    check("t1_ec", err_cnt, 32'd0);

    // back to HUNT via alignment loss
    aligned = 1'b0; step();
    check("t2_unlock", locked, 1'b0);
    check("t2_wc_hold", word_cnt, 48'd1);

    // 2: 3 x lane 2, then 4 x lane 5
    put_good(2);
    step(); step(); step();
    check("t2_lane2_nolock", locked, 1'b0);
    put_good(5);
    step(); step(); step();
    check("t2_lane5_3", locked, 1'b0);
    step();
    check("t2_lock", locked, 1'b1);
    check("t2_kpos", k_pos, 3'd5);
    check("t2_err_hunt", err, 1'b0);

    // 3: relock on lane 3, inject one corrupted byte
    aligned = 1'b0; step();
    put_good(3);
    step(); step(); step(); step();
    check("t3_lock", locked, 1'b1);
    check("t3_kpos", k_pos, 3'd3);
    check("t3_wc", word_cnt, 48'd1);
    data = 64'hA44A4A4A_BC4A4A4A; step();
    check("t3_err", err, 1'b1);
    check("t3_ec", err_cnt, 32'd1);
    check("t3_locked", locked, 1'b1);
    check("t3_wc2", word_cnt, 48'd2);
    put_good(3); step();
    check("t3_err_pulse", err, 1'b0);
    check("t3_wc3", word_cnt, 48'd3);

    // 4: clear, 3 bad, good, 4 bad
    clr = 1'b1; step(); clr = 1'b0;
    check("t4_clr_ec", err_cnt, 32'd0);
    check("t4_clr_wc", word_cnt, 48'd0);
    nit = 8'h10;
    step(); step(); step();
    check("t4_ec3", err_cnt, 32'd3);
    check("t4_locked3", locked, 1'b1);
    nit = 8'h00; step();
    check("t4_good_err", err, 1'b0);
    nit = 8'h10;
    step(); step(); step();
    check("t4_bad3_locked", locked, 1'b1);
    step();
    check("t4_loss", locked, 1'b0);
    check("t4_ec7", err_cnt, 32'd7);
    check("t4_wc8", word_cnt, 48'd8);
    step();
    check("t4_hunt_silent", err, 1'b0);
    check("t4_hunt_ec", err_cnt, 32'd7);
    check("t4_hunt_wc", word_cnt, 48'd8);

    // 5: relock, then one-cycle alignment loss
    put_good(3);
    step(); step(); step(); step();
    check("t5_lock", locked, 1'b1);
    step();
    check("t5_wc9", word_cnt, 48'd9);
    aligned = 1'b0; step();
    check("t5_unlock", locked, 1'b0);
    check("t5_wc_hold", word_cnt, 48'd9);
    check("t5_ec_hold", err_cnt, 32'd7);
    check("t5_err_quiet", err, 1'b0);
    put_good(3);
    step(); step(); step();
    check("t5_relock3", locked, 1'b0);
    step();
    check("t5_relock", locked, 1'b1);
    check("t5_kpos", k_pos, 3'd3);

    // good pattern on the wrong lane is an error while locked
    put_good(0); step();
    check("t5_wronglane_err", err, 1'b1);
    check("t5_wronglane_ec", err_cnt, 32'd8);
    check("t5_wronglane_wc", word_cnt, 48'd10);

    // 6: clear coincident with a bad word
    data = 64'hA44A4A4A_BC4A4A4A; kf = 8'h08; clr = 1'b1; step(); clr = 1'b0;
    check("t6_err", err, 1'b1);
    check("t6_ec", err_cnt, 32'd0);
    check("t6_wc", word_cnt, 48'd0);
    check("t6_locked", locked, 1'b1);
    put_good(3); step();
    check("t6_wc1", word_cnt, 48'd1);
    check("t6_locked2", locked, 1'b1);

    // asynchronous reset mid-CHECK, checked before the next edge
    rstn = 1'b0; #2;
    check("t6_arst_locked", locked, 1'b0);
    check("t6_arst_kpos", k_pos, 3'd0);
    check("t6_arst_err", err, 1'b0);
    check("t6_arst_ec", err_cnt, 32'd0);
    check("t6_arst_wc", word_cnt, 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
